// File: rtl/tbird_pkg.sv
// Shared types for the Thunderbird lamp decoder: lamp bundle, modes, states, patterns, error codes.
// Optional hazard support is selected with the TBIRD_HAZARD_EN macro.
package tbird_pkg;

   typedef struct packed {
      logic lc;
      logic lb;
      logic la;
      logic ra;
      logic rb;
      logic rc;
   } lamp_t;

   typedef enum logic [1:0] {
      MODE_IDLE   = 2'd0,
      MODE_LEFT   = 2'd1,
      MODE_RIGHT  = 2'd2,
      MODE_HAZARD = 2'd3
   } mode_e;

   typedef enum logic [3:0] {
      S_OFF,
      S_L1,
      S_L2,
      S_L3,
      S_R1,
      S_R2,
      S_R3,
`ifdef TBIRD_HAZARD_EN
      S_HAZ,
`endif
      S_RESYNC
   } dec_state_e;

   typedef enum logic [3:0] {
      P_OFF,
      P_L1,
      P_L2,
      P_L3,
      P_R1,
      P_R2,
      P_R3,
      P_ALL,
      P_MIXED,
      P_GAP
   } pattern_e;

   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_ILLEGAL = 3'd1;
   localparam logic [2:0] ERR_ORDER   = 3'd2;
   localparam logic [2:0] ERR_MIXED   = 3'd3;
   localparam logic [2:0] ERR_HAZARD  = 3'd4;

   function automatic mode_e mode_of(input dec_state_e s);
      mode_e m;
      case (s)
         S_L1, S_L2, S_L3: m = MODE_LEFT;
         S_R1, S_R2, S_R3: m = MODE_RIGHT;
`ifdef TBIRD_HAZARD_EN
         S_HAZ:            m = MODE_HAZARD;
`endif
         default:          m = MODE_IDLE;
      endcase
      return m;
   endfunction

   function automatic logic [1:0] phase_of(input dec_state_e s);
      logic [1:0] p;
      case (s)
         S_L1, S_R1:        p = 2'd1;
         S_L2, S_R2:        p = 2'd2;
         S_L3, S_R3:        p = 2'd3;
`ifdef TBIRD_HAZARD_EN
         S_HAZ:             p = 2'd3;
`endif
         default:           p = 2'd0;
      endcase
      return p;
   endfunction

   // A recognisable shape arriving at the wrong moment is an ordering error.
   function automatic logic [2:0] err_class(input pattern_e p);
      logic [2:0] c;
      case (p)
         P_GAP:   c = ERR_ILLEGAL;
         P_MIXED: c = ERR_MIXED;
`ifdef TBIRD_HAZARD_EN
         P_ALL:   c = ERR_ORDER;
`else
         P_ALL:   c = ERR_HAZARD;
`endif
         default: c = ERR_ORDER;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tbird_pattern_classify.sv
// Combinational classifier: maps the six lamp bits onto one of the named lamp patterns.
module tbird_pattern_classify
   import tbird_pkg::*;
(
   input  lamp_t    lamps,
   output pattern_e pattern
);

   logic [2:0] left_bits;
   logic [2:0] right_bits;

   assign left_bits  = {lamps.lc, lamps.lb, lamps.la};
   assign right_bits = {lamps.rc, lamps.rb, lamps.ra};

   // Legal single-side shapes fill from the inner lamp outward with no holes.
   always_comb begin
      pattern = P_GAP;
      if (left_bits == 3'b000 && right_bits == 3'b000) begin
         pattern = P_OFF;
      end else if (left_bits == 3'b111 && right_bits == 3'b111) begin
         pattern = P_ALL;
      end else if (left_bits != 3'b000 && right_bits != 3'b000) begin
         pattern = P_MIXED;
      end else if (right_bits == 3'b000) begin
         case (left_bits)
            3'b001:  pattern = P_L1;
            3'b011:  pattern = P_L2;
            3'b111:  pattern = P_L3;
            default: pattern = P_GAP;
         endcase
      end else begin
         case (right_bits)
            3'b001:  pattern = P_R1;
            3'b011:  pattern = P_R2;
            3'b111:  pattern = P_R3;
            default: pattern = P_GAP;
         endcase
      end
   end

endmodule

// File: rtl/tbird_lamp_decoder.sv
// Checks the lamp sequence of the Thunderbird turn-signal FSM, counting completed runs and latching the first error.
// Define TBIRD_HAZARD_EN to accept the all-lamps hazard sequence.
module tbird_lamp_decoder
   import tbird_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             la,
   input  logic             lb,
   input  logic             lc,
   input  logic             ra,
   input  logic             rb,
   input  logic             rc,
   input  logic             err_clr,
   output logic [1:0]       mode,
   output logic [1:0]       phase,
   output logic             seq_done,
   output logic [CNT_W-1:0] left_cnt,
   output logic [CNT_W-1:0] right_cnt,
   output logic             err,
   output logic [2:0]       err_code
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   lamp_t      lamps;
   pattern_e   pattern;
   dec_state_e state_q, state_d;
   logic       seq_done_q, seq_done_d;
   logic [CNT_W-1:0] left_cnt_q, left_cnt_d;
   logic [CNT_W-1:0] right_cnt_q, right_cnt_d;
   logic       err_q, err_d;
   logic [2:0] err_code_q, err_code_d;
   logic       bad_step;
   logic       left_done;
   logic       right_done;

   assign lamps = {lc, lb, la, ra, rb, rc};

   tbird_pattern_classify u_classify (
      .lamps   (lamps),
      .pattern (pattern)
   );

   // Each sequence state accepts exactly one successor pattern; anything else drops to RESYNC.
   always_comb begin
      state_d    = state_q;
      bad_step   = 1'b0;
      seq_done_d = 1'b0;
      left_done  = 1'b0;
      right_done = 1'b0;
      if (step) begin
         case (state_q)
            S_OFF: begin
               case (pattern)
                  P_OFF:   state_d = S_OFF;
                  P_L1:    state_d = S_L1;
                  P_R1:    state_d = S_R1;
`ifdef TBIRD_HAZARD_EN
                  P_ALL:   state_d = S_HAZ;
`endif
                  default: bad_step = 1'b1;
               endcase
            end
            S_L1: if (pattern == P_L2) state_d = S_L2; else bad_step = 1'b1;
            S_L2: if (pattern == P_L3) state_d = S_L3; else bad_step = 1'b1;
            S_L3: begin
               if (pattern == P_OFF) begin
                  state_d    = S_OFF;
                  seq_done_d = 1'b1;
                  left_done  = 1'b1;
               end else begin
                  bad_step = 1'b1;
               end
            end
            S_R1: if (pattern == P_R2) state_d = S_R2; else bad_step = 1'b1;
            S_R2: if (pattern == P_R3) state_d = S_R3; else bad_step = 1'b1;
            S_R3: begin
               if (pattern == P_OFF) begin
                  state_d    = S_OFF;
                  seq_done_d = 1'b1;
                  right_done = 1'b1;
               end else begin
                  bad_step = 1'b1;
               end
            end
`ifdef TBIRD_HAZARD_EN
            S_HAZ: begin
               if (pattern == P_OFF) begin
                  state_d    = S_OFF;
                  seq_done_d = 1'b1;
               end else begin
                  bad_step = 1'b1;
               end
            end
`endif
            S_RESYNC: if (pattern == P_OFF) state_d = S_OFF;
            default:  state_d = S_OFF;
         endcase
         if (bad_step) state_d = S_RESYNC;
      end
   end

   // A fresh error overrides a same-cycle clear; otherwise the first code is kept until cleared.
   always_comb begin
      left_cnt_d  = left_cnt_q;
      right_cnt_d = right_cnt_q;
      err_d       = err_q;
      err_code_d  = err_code_q;
      if (left_done && left_cnt_q != CNT_MAX) left_cnt_d = left_cnt_q + 1'b1;
      if (right_done && right_cnt_q != CNT_MAX) right_cnt_d = right_cnt_q + 1'b1;
      if (bad_step) begin
         err_d = 1'b1;
         if (!err_q || err_clr) err_code_d = err_class(pattern);
      end else if (err_clr) begin
         err_d      = 1'b0;
         err_code_d = ERR_NONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_OFF;
         seq_done_q  <= 1'b0;
         left_cnt_q  <= '0;
         right_cnt_q <= '0;
         err_q       <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         seq_done_q  <= seq_done_d;
         left_cnt_q  <= left_cnt_d;
         right_cnt_q <= right_cnt_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign mode      = mode_of(state_q);
   assign phase     = phase_of(state_q);
   assign seq_done  = seq_done_q;
   assign left_cnt  = left_cnt_q;
   assign right_cnt = right_cnt_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_tbird_lamp_decoder.sv
// Self-checking bench for tbird_lamp_decoder: directed scenarios then random lamp steps against a side/phase model.
// Honours TBIRD_HAZARD_EN in the same way as the design.
module tb_tbird_lamp_decoder;

   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef TBIRD_HAZARD_EN
   localparam bit HAZ_EN = 1'b1;
`else
   localparam bit HAZ_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             step = 1'b0;
   logic             la = 1'b0, lb = 1'b0, lc = 1'b0;
   logic             ra = 1'b0, rb = 1'b0, rc = 1'b0;
   logic             err_clr = 1'b0;
   logic [1:0]       mode;
   logic [1:0]       phase;
   logic             seq_done;
   logic [CNT_W-1:0] left_cnt;
   logic [CNT_W-1:0] right_cnt;
   logic             err;
   logic [2:0]       err_code;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: which side is running, how many lamps are lit, and whether we are resyncing.
   int m_side;
   int m_phase;
   bit m_resync;
   bit m_done;
   int m_lcnt;
   int m_rcnt;
   bit m_err;
   int m_code;

   tbird_lamp_decoder #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .step      (step),
      .la        (la),
      .lb        (lb),
      .lc        (lc),
      .ra        (ra),
      .rb        (rb),
      .rc        (rc),
      .err_clr   (err_clr),
      .mode      (mode),
      .phase     (phase),
      .seq_done  (seq_done),
      .left_cnt  (left_cnt),
      .right_cnt (right_cnt),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_side = 0; m_phase = 0; m_resync = 0; m_done = 0;
      m_lcnt = 0; m_rcnt = 0; m_err = 0; m_code = 0;
   endtask

   task automatic model_latch(input int new_code, input bit clr);
      if (new_code != 0) begin
         if (!m_err || clr) m_code = new_code;
         m_err = 1;
      end else if (clr) begin
         m_err = 0;
         m_code = 0;
      end
   endtask

   // lv/rv hold the lamps of each side with bit0 = inner lamp.
   task automatic model_step(input logic [2:0] lv, input logic [2:0] rv, input bit clr);
      int new_code = 0;
      int side;
      int n;
      int val;
      m_done = 0;
      if (m_resync) begin
         if (lv == 0 && rv == 0) m_resync = 0;
      end else begin
         if (lv == 0 && rv == 0) begin
            if (m_side == 3 || m_phase == 3) begin
               m_done = 1;
               if (m_side == 1 && m_lcnt < CNT_MAX) m_lcnt++;
               if (m_side == 2 && m_rcnt < CNT_MAX) m_rcnt++;
               m_side = 0;
               m_phase = 0;
            end else if (m_side != 0) begin
               new_code = 2;
            end
         end else if (lv == 7 && rv == 7) begin
            if (!HAZ_EN) new_code = 4;
            else if (m_side == 0) begin m_side = 3; m_phase = 3; end
            else new_code = 2;
         end else if (lv != 0 && rv != 0) begin
            new_code = 3;
         end else begin
            side = (lv != 0) ? 1 : 2;
            val  = (lv != 0) ? int'(lv) : int'(rv);
            n    = $countones(val);
            if (val != (1 << n) - 1) new_code = 1;
            else if ((m_side == 0 || m_side == side) && n == m_phase + 1) begin
               m_side = side;
               m_phase = n;
            end else new_code = 2;
         end
         if (new_code != 0) begin
            m_resync = 1;
            m_side = 0;
            m_phase = 0;
         end
      end
      model_latch(new_code, clr);
   endtask

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      check_val("mode", 8'(mode), 8'(m_side));
      check_val("phase", 8'(phase), 8'(m_phase));
      check_val("seq_done", 8'(seq_done), 8'(m_done));
      check_val("left_cnt", 8'(left_cnt), 8'(m_lcnt));
      check_val("right_cnt", 8'(right_cnt), 8'(m_rcnt));
      check_val("err", 8'(err), 8'(m_err));
      check_val("err_code", 8'(err_code), 8'(m_code));
   endtask

   // Drive one cycle at posedge+1, let the DUT sample, then check just after the next edge.
   task automatic applyStimulus(input logic [2:0] lv, input logic [2:0] rv, input bit st, input bit clr);
      la = lv[0]; lb = lv[1]; lc = lv[2];
      ra = rv[0]; rb = rv[1]; rc = rv[2];
      step = st;
      err_clr = clr;
      @(posedge clk);
      if (st) model_step(lv, rv, clr);
      else begin
         m_done = 0;
         model_latch(0, clr);
      end
      #1;
      checkOutput();
      step = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic do_step(input logic [2:0] lv, input logic [2:0] rv);
      applyStimulus(lv, rv, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      checkOutput();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic run_side(input bit left);
      for (int i = 1; i <= 3; i++) begin
         logic [2:0] v;
         v = 3'((1 << i) - 1);
         if (left) do_step(v, 3'b000); else do_step(3'b000, v);
      end
      do_step(3'b000, 3'b000);
   endtask

   initial begin
      logic [5:0] pick;
      int r;
      model_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput();
      reset = 1'b1;

      $display("[TB] left run");
      do_step(3'b000, 3'b000);
      run_side(1'b1);
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);

      $display("[TB] three right runs");
      repeat (3) run_side(1'b0);
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);

      $display("[TB] skip and resync");
      do_step(3'b000, 3'b000);
      do_step(3'b001, 3'b000);
      do_step(3'b111, 3'b000);
      do_step(3'b000, 3'b000);
      do_step(3'b000, 3'b001);

      $display("[TB] mixed sides and clear");
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);
      do_step(3'b001, 3'b001);
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);
      do_step(3'b000, 3'b000);

      $display("[TB] hazard");
      do_step(3'b000, 3'b000);
      do_step(3'b111, 3'b111);
      do_step(3'b000, 3'b000);
      applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);

      $display("[TB] error and clear on the same cycle");
      do_step(3'b011, 3'b000);
      do_step(3'b000, 3'b000);
      applyStimulus(3'b101, 3'b000, 1'b1, 1'b1);
      do_step(3'b000, 3'b000);
      do_step(3'b000, 3'b110);
      applyStimulus(3'b000, 3'b000, 1'b1, 1'b1);

      $display("[TB] left counter saturation");
      repeat (5) run_side(1'b1);

      $display("[TB] reset mid-sequence");
      do_step(3'b001, 3'b000);
      do_step(3'b011, 3'b000);
      #3;
      do_reset();
      do_step(3'b011, 3'b000);
      do_step(3'b000, 3'b000);

      $display("[TB] random steps");
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            continue;
         end
         if ($urandom_range(0, 9) < 6) begin
            if (m_resync || m_phase == 3) pick = 6'b000000;
            else if (m_side == 0) begin
               r = $urandom_range(0, 3);
               case (r)
                  0:       pick = 6'b000000;
                  1:       pick = 6'b001000;
                  2:       pick = 6'b000001;
                  default: pick = 6'b111111;
               endcase
            end else begin
               pick = 6'(((1 << (m_phase + 1)) - 1) << ((m_side == 1) ? 3 : 0));
            end
         end else begin
            pick = 6'($urandom);
         end
         applyStimulus(pick[5:3], pick[2:0], $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
